// File: rtl/lsu_mem_stage_if.sv
// ============================================================================
// Module  : lsu_mem_stage_if
// Brief   : Data-memory handshake bus between the load/store unit (master)
//           and the data memory (slave).
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface lsu_mem_stage_if #(
   parameter int AW = 32
);
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [3:0]    mem_be;
   logic [31:0]   mem_wdata;
   logic          mem_ready;
   logic [31:0]   mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_ready, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_ready, mem_rdata
   );
endinterface

`default_nettype wire

// File: rtl/lsu_mem_stage.sv
// ============================================================================
// Module  : lsu_mem_stage
// Brief   : Memory-stage load/store unit. Decodes load/store codes, runs one
//           handshaked data-memory access, builds byte enables and store
//           lanes, extends load data, stalls the pipeline and flags
//           misaligned accesses without touching memory.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module lsu_mem_stage #(
   parameter int AW = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [2:0]            rd_en,
   input  logic [2:0]            wr_en,
   input  logic [AW-1:0]         addr,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata,
   output logic                  stall,
   output logic                  misalign,
   lsu_mem_stage_if.master       mem
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [2:0] LD_LB  = 3'd1;
   localparam logic [2:0] LD_LBU = 3'd2;
   localparam logic [2:0] LD_LH  = 3'd3;
   localparam logic [2:0] LD_LHU = 3'd4;
   localparam logic [2:0] LD_LW  = 3'd5;

   localparam logic [2:0] ST_SB  = 3'd1;
   localparam logic [2:0] ST_SH  = 3'd2;
   localparam logic [2:0] ST_SW  = 3'd3;

   logic [1:0]    r_state;
   logic [2:0]    r_ld_type;   // 0 for stores, else the load code
   logic          r_we;
   logic [AW-1:0] r_addr;
   logic [3:0]    r_be;
   logic [31:0]   r_wdata;
   logic          r_err;
   logic [31:0]   r_rdata;

   logic          w_ld_ok;
   logic          w_st_ok;
   logic          w_op;
   logic          w_mis;
   logic [3:0]    w_be;
   logic [31:0]   w_wdata;
   logic [7:0]    w_byte;
   logic [15:0]   w_half;
   logic [31:0]   w_ext;

   // Decode the incoming codes; loads win over stores, reserved codes are no-ops
   always_comb begin
      w_ld_ok = (rd_en >= LD_LB) && (rd_en <= LD_LW);
      w_st_ok = !w_ld_ok && (wr_en >= ST_SB) && (wr_en <= ST_SW);
      w_op    = (w_ld_ok || w_st_ok) && !rst;
      w_mis   = 1'b0;
      w_be    = 4'b0000;
      w_wdata = 32'h0;
      if (w_ld_ok) begin
         w_be  = 4'b1111;
         w_mis = (((rd_en == LD_LH) || (rd_en == LD_LHU)) && addr[0]) ||
                 ((rd_en == LD_LW) && (addr[1:0] != 2'b00));
      end else if (w_st_ok) begin
         case (wr_en)
            ST_SB: begin
               w_be    = 4'b0001 << addr[1:0];
               w_wdata = {4{wdata[7:0]}};
            end
            ST_SH: begin
               w_be    = 4'b0011 << {addr[1], 1'b0};
               w_wdata = {2{wdata[15:0]}};
               w_mis   = addr[0];
            end
            default: begin
               w_be    = 4'b1111;
               w_wdata = wdata;
               w_mis   = (addr[1:0] != 2'b00);
            end
         endcase
      end
   end

   // Extract the addressed lane of the returned word and extend it
   always_comb begin
      w_byte = mem.mem_rdata[{r_addr[1:0], 3'b000} +: 8];
      w_half = r_addr[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
      case (r_ld_type)
         LD_LB:   w_ext = {{24{w_byte[7]}}, w_byte};
         LD_LBU:  w_ext = {24'h0, w_byte};
         LD_LH:   w_ext = {{16{w_half[15]}}, w_half};
         LD_LHU:  w_ext = {16'h0, w_half};
         default: w_ext = mem.mem_rdata;
      endcase
   end

   // Access FSM: latch the op in IDLE, handshake in BUSY, release in DONE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_ld_type <= 3'd0;
         r_we      <= 1'b0;
         r_addr    <= '0;
         r_be      <= 4'b0000;
         r_wdata   <= 32'h0;
         r_err     <= 1'b0;
         r_rdata   <= 32'h0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_op) begin
                  r_ld_type <= w_ld_ok ? rd_en : 3'd0;
                  r_we      <= w_st_ok;
                  r_addr    <= addr;
                  r_be      <= w_be;
                  r_wdata   <= w_wdata;
                  r_err     <= w_mis;
                  r_state   <= w_mis ? S_DONE : S_BUSY;
               end
            end
            S_BUSY: begin
               if (mem.mem_ready) begin
                  if (!r_we) begin
                     r_rdata <= w_ext;
                  end
                  r_state <= S_DONE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign stall         = ((r_state == S_IDLE) && w_op) || (r_state == S_BUSY);
   assign misalign      = (r_state == S_DONE) && r_err;
   assign rdata         = r_rdata;
   assign mem.mem_req   = (r_state == S_BUSY);
   assign mem.mem_we    = r_we;
   assign mem.mem_addr  = {r_addr[AW-1:2], 2'b00};
   assign mem.mem_be    = r_be;
   assign mem.mem_wdata = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_stage.sv
// ============================================================================
// Module  : tb_lsu_mem_stage
// Brief   : Directed self-checking bench for lsu_mem_stage.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lsu_mem_stage;

   localparam int AW = 32;

   logic          clk;
   logic          rst;
   logic [2:0]    rd_en;
   logic [2:0]    wr_en;
   logic [AW-1:0] addr;
   logic [31:0]   wdata;
   logic [31:0]   rdata;
   logic          stall;
   logic          misalign;

   int checks = 0;
   int errors = 0;

   lsu_mem_stage_if #(.AW(AW)) mem_if ();

   lsu_mem_stage #(.AW(AW)) dut (
      .clk      (clk),
      .rst      (rst),
      .rd_en    (rd_en),
      .wr_en    (wr_en),
      .addr     (addr),
      .wdata    (wdata),
      .rdata    (rdata),
      .stall    (stall),
      .misalign (misalign),
      .mem      (mem_if.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle_inputs();
      rd_en = 3'd0;
      wr_en = 3'd0;
      mem_if.mem_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      rd_en = 3'd0; wr_en = 3'd0; addr = '0; wdata = 32'h0;
      mem_if.mem_ready = 1'b0; mem_if.mem_rdata = 32'h0;
      #3;
      chk("rst_stall", {31'h0, stall}, 32'h0);
      chk("rst_misalign", {31'h0, misalign}, 32'h0);
      chk("rst_req", {31'h0, mem_if.mem_req}, 32'h0);
      chk("rst_we", {31'h0, mem_if.mem_we}, 32'h0);
      chk("rst_be", {28'h0, mem_if.mem_be}, 32'h0);
      chk("rst_addr", mem_if.mem_addr, 32'h0);
      chk("rst_wdata", mem_if.mem_wdata, 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      tick(); tick();
      rst = 1'b0;
      tick();

      // LB at 0x103: sign-extend the top byte
      rd_en = 3'd1; addr = 32'h103; #1;
      chk("lb_idle_stall", {31'h0, stall}, 32'h1);
      chk("lb_idle_req", {31'h0, mem_if.mem_req}, 32'h0);
      tick();
      chk("lb_busy_req", {31'h0, mem_if.mem_req}, 32'h1);
      chk("lb_busy_stall", {31'h0, stall}, 32'h1);
      chk("lb_addr", mem_if.mem_addr, 32'h100);
      chk("lb_be", {28'h0, mem_if.mem_be}, 32'hF);
      chk("lb_we", {31'h0, mem_if.mem_we}, 32'h0);
      mem_if.mem_ready = 1'b1; mem_if.mem_rdata = 32'h80FF1234;
      tick();
      chk("lb_rdata", rdata, 32'hFFFFFF80);
      chk("lb_done_stall", {31'h0, stall}, 32'h0);
      chk("lb_done_req", {31'h0, mem_if.mem_req}, 32'h0);
      chk("lb_done_mis", {31'h0, misalign}, 32'h0);
      idle_inputs();
      tick();
      chk("lb_after_stall", {31'h0, stall}, 32'h0);

      // LBU at 0x103: zero-extend
      rd_en = 3'd2; addr = 32'h103; #1;
      chk("lbu_idle_stall", {31'h0, stall}, 32'h1);
      tick();
      mem_if.mem_ready = 1'b1; mem_if.mem_rdata = 32'h80FF1234;
      tick();
      chk("lbu_rdata", rdata, 32'h00000080);
      idle_inputs();
      tick();

      // SH at 0x102
      wr_en = 3'd2; addr = 32'h102; wdata = 32'h1234BEEF; #1;
      chk("sh_idle_stall", {31'h0, stall}, 32'h1);
      tick();
      chk("sh_we", {31'h0, mem_if.mem_we}, 32'h1);
      chk("sh_be", {28'h0, mem_if.mem_be}, 32'hC);
      chk("sh_wdata", mem_if.mem_wdata, 32'hBEEFBEEF);
      chk("sh_addr", mem_if.mem_addr, 32'h100);
      mem_if.mem_ready = 1'b1;
      tick();
      chk("sh_rdata_kept", rdata, 32'h00000080);
      chk("sh_done_stall", {31'h0, stall}, 32'h0);
      idle_inputs();
      tick();

      // SB at 0x101
      wr_en = 3'd1; addr = 32'h101; wdata = 32'h000000AB;
      tick();
      chk("sb_be", {28'h0, mem_if.mem_be}, 32'h2);
      chk("sb_wdata", mem_if.mem_wdata, 32'hABABABAB);
      mem_if.mem_ready = 1'b1;
      tick();
      idle_inputs();
      tick();

      // LW at 0x200 with two wait states
      rd_en = 3'd5; addr = 32'h200; #1;
      chk("lw_idle_stall", {31'h0, stall}, 32'h1);
      tick();
      chk("lw_b1_req", {31'h0, mem_if.mem_req}, 32'h1);
      chk("lw_b1_stall", {31'h0, stall}, 32'h1);
      tick();
      chk("lw_b2_req", {31'h0, mem_if.mem_req}, 32'h1);
      chk("lw_b2_stall", {31'h0, stall}, 32'h1);
      chk("lw_b2_addr", mem_if.mem_addr, 32'h200);
      tick();
      chk("lw_b3_req", {31'h0, mem_if.mem_req}, 32'h1);
      chk("lw_b3_stall", {31'h0, stall}, 32'h1);
      mem_if.mem_ready = 1'b1; mem_if.mem_rdata = 32'hDEADBEEF;
      tick();
      chk("lw_rdata", rdata, 32'hDEADBEEF);
      chk("lw_done_stall", {31'h0, stall}, 32'h0);
      chk("lw_done_req", {31'h0, mem_if.mem_req}, 32'h0);
      idle_inputs();
      tick();

      // LH at 0x102: sign-extend the upper half
      rd_en = 3'd3; addr = 32'h102;
      tick();
      mem_if.mem_ready = 1'b1; mem_if.mem_rdata = 32'h80017FFF;
      tick();
      chk("lh_rdata", rdata, 32'hFFFF8001);
      idle_inputs();
      tick();

      // Misaligned LW at 0x101; ready held high to show it is ignored
      rd_en = 3'd5; addr = 32'h101; mem_if.mem_ready = 1'b1;
      mem_if.mem_rdata = 32'h55555555; #1;
      chk("mis_idle_stall", {31'h0, stall}, 32'h1);
      chk("mis_idle_req", {31'h0, mem_if.mem_req}, 32'h0);
      tick();
      chk("mis_pulse", {31'h0, misalign}, 32'h1);
      chk("mis_done_req", {31'h0, mem_if.mem_req}, 32'h0);
      chk("mis_done_stall", {31'h0, stall}, 32'h0);
      chk("mis_rdata_kept", rdata, 32'hFFFF8001);
      idle_inputs();
      tick();
      chk("mis_pulse_end", {31'h0, misalign}, 32'h0);
      chk("mis_after_req", {31'h0, mem_if.mem_req}, 32'h0);

      // Load and store codes together: the load wins
      rd_en = 3'd5; wr_en = 3'd3; addr = 32'h300; wdata = 32'h99999999;
      tick();
      chk("both_we", {31'h0, mem_if.mem_we}, 32'h0);
      chk("both_be", {28'h0, mem_if.mem_be}, 32'hF);
      chk("both_req", {31'h0, mem_if.mem_req}, 32'h1);
      mem_if.mem_ready = 1'b1; mem_if.mem_rdata = 32'h11223344;
      tick();
      chk("both_rdata", rdata, 32'h11223344);
      idle_inputs();
      tick();

      // Reserved load code alone is a no-op
      rd_en = 3'd7; addr = 32'h400; #1;
      chk("rsv_stall", {31'h0, stall}, 32'h0);
      tick();
      chk("rsv_req", {31'h0, mem_if.mem_req}, 32'h0);
      chk("rsv_stall2", {31'h0, stall}, 32'h0);
      idle_inputs();
      tick();

      // Asynchronous reset in the middle of a BUSY SW
      wr_en = 3'd3; addr = 32'h400; wdata = 32'hCAFEF00D;
      tick();
      chk("sw_busy_req", {31'h0, mem_if.mem_req}, 32'h1);
      chk("sw_busy_wdata", mem_if.mem_wdata, 32'hCAFEF00D);
      #1 rst = 1'b1;
      #1;
      chk("arst_req", {31'h0, mem_if.mem_req}, 32'h0);
      chk("arst_stall", {31'h0, stall}, 32'h0);
      chk("arst_rdata", rdata, 32'h0);
      idle_inputs();
      tick();
      rst = 1'b0;
      tick();
      tick();
      chk("post_rst_stall", {31'h0, stall}, 32'h0);
      chk("post_rst_req", {31'h0, mem_if.mem_req}, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
